// File: rtl/cache_line_fill_pkg.sv
// Shared constants for the cache line refill path: FSM encoding of the fill
// engine and the derived line/index widths also used by the cache controller.
package cache_line_fill_pkg;

  // Default geometry of the data array.
  localparam int unsigned WordWidthDef   = 32;
  localparam int unsigned WordsPerLineDef = 4;
  localparam int unsigned NLinesDef      = 64;

  // Width of one full line in bits.
  function automatic int unsigned line_width(input int unsigned word_width,
                                             input int unsigned words_per_line);
    return word_width * words_per_line;
  endfunction

  // Derived widths for the default geometry.
  localparam int unsigned LineWidthDef = WordWidthDef * WordsPerLineDef;
  localparam int unsigned LineIdxWDef  = $clog2(NLinesDef);
  localparam int unsigned WordIdxWDef  = $clog2(WordsPerLineDef);

  // Fill engine state encoding.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/cache_line_fill.sv
// Line refill engine: collects WORDS_PER_LINE in-order beats, forwards the
// critical word early, then commits the assembled line to the data SRAM in a
// single write cycle and pulses done.
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = WordWidthDef,
  parameter int unsigned WORDS_PER_LINE = WordsPerLineDef,
  parameter int unsigned N_LINES        = NLinesDef,
  localparam int unsigned LineWidth     = line_width(WORD_WIDTH, WORDS_PER_LINE),
  localparam int unsigned LineIdxW      = $clog2(N_LINES),
  localparam int unsigned WordIdxW      = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Fill request
  input  logic                  req_i,
  input  logic [LineIdxW-1:0]   req_line_i,
  input  logic [WordIdxW-1:0]   req_word_i,
  output logic                  busy_o,
  // Memory-side beats
  input  logic [WORD_WIDTH-1:0] mem_data_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  // Critical word to the core
  output logic [WORD_WIDTH-1:0] crit_data_o,
  output logic                  crit_valid_o,
  // Data SRAM write port
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [LineIdxW-1:0]   sram_addr_o,
  output logic [LineWidth-1:0]  sram_data_o,
  output logic                  done_o
);

  localparam logic [WordIdxW-1:0] LastWord = WordIdxW'(WORDS_PER_LINE - 1);

  logic [1:0]            state_q, state_d;
  logic [WordIdxW-1:0]   cnt_q, cnt_d;
  logic [LineIdxW-1:0]   line_q, line_d;
  logic [WordIdxW-1:0]   word_q, word_d;
  logic [LineWidth-1:0]  buf_q, buf_d;
  logic [WORD_WIDTH-1:0] crit_data_q, crit_data_d;
  logic                  crit_valid_q, crit_valid_d;
  logic [LineIdxW-1:0]   sram_addr_q, sram_addr_d;
  logic [LineWidth-1:0]  sram_data_q, sram_data_d;

  logic beat_acc;
  logic last_beat;

  // Beat handshake decode.
  always_comb begin
    beat_acc  = (state_q == StFill) && mem_valid_i;
    last_beat = beat_acc && (cnt_q == LastWord);
  end

  // FSM next state and request capture.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          line_d  = req_line_i;
          word_d  = req_word_i;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (beat_acc) begin
          cnt_d = cnt_q + WordIdxW'(1);
        end
        if (last_beat) begin
          state_d = StWrite;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Line assembly, critical-word capture and SRAM write staging.
  always_comb begin
    buf_d        = buf_q;
    crit_data_d  = crit_data_q;
    crit_valid_d = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_data_d  = sram_data_q;
    for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
      if (beat_acc && (cnt_q == WordIdxW'(k))) begin
        buf_d[k*WORD_WIDTH +: WORD_WIDTH] = mem_data_i;
      end
    end
    if (beat_acc && (cnt_q == word_q)) begin
      crit_data_d  = mem_data_i;
      crit_valid_d = 1'b1;
    end
    // Stage the complete line (including the final beat) so it is presented
    // in the WRITE cycle and then held afterwards.
    if (last_beat) begin
      sram_addr_d = line_q;
      sram_data_d = buf_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      line_q       <= '0;
      word_q       <= '0;
      buf_q        <= '0;
      crit_data_q  <= '0;
      crit_valid_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      word_q       <= word_d;
      buf_q        <= buf_d;
      crit_data_q  <= crit_data_d;
      crit_valid_q <= crit_valid_d;
      sram_addr_q  <= sram_addr_d;
      sram_data_q  <= sram_data_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy_o       = (state_q != StIdle);
    mem_ready_o  = (state_q == StFill);
    sram_en_o    = (state_q == StWrite);
    sram_we_o    = (state_q == StWrite);
    done_o       = (state_q == StDone);
    crit_data_o  = crit_data_q;
    crit_valid_o = crit_valid_q;
    sram_addr_o  = sram_addr_q;
    sram_data_o  = sram_data_q;
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: expected critical words, SRAM writes
// and done pulses are queued as beats are driven and checked as they appear.
module tb_cache_line_fill;
  import cache_line_fill_pkg::*;

  localparam int unsigned WW  = WordWidthDef;
  localparam int unsigned WPL = WordsPerLineDef;
  localparam int unsigned NL  = NLinesDef;
  localparam int unsigned LW  = LineWidthDef;
  localparam int unsigned LIW = LineIdxWDef;
  localparam int unsigned WIW = WordIdxWDef;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req = 1'b0;
  logic [LIW-1:0] req_line = '0;
  logic [WIW-1:0] req_word = '0;
  logic           busy;
  logic [WW-1:0]  mem_data = '0;
  logic           mem_valid = 1'b0;
  logic           mem_ready;
  logic [WW-1:0]  crit_data;
  logic           crit_valid;
  logic           sram_en;
  logic           sram_we;
  logic [LIW-1:0] sram_addr;
  logic [LW-1:0]  sram_data;
  logic           done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [WW-1:0] data;
    int            cycle;
  } crit_exp_t;

  typedef struct {
    logic [LIW-1:0] addr;
    logic [LW-1:0]  data;
    int             cycle;
  } wr_exp_t;

  crit_exp_t crit_sb[$];
  wr_exp_t   wr_sb[$];
  int        done_sb[$];
  crit_exp_t ce;
  wr_exp_t   we_e;
  int        de;

  logic [LW-1:0] sram_model [NL];
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_crit_cyc = -1;
  int last_wr_cyc = -1;
  int last_done_cyc = -1;

  localparam logic [LW-1:0] LineBasic = 128'h44444444_33333333_22222222_11111111;
  localparam logic [LW-1:0] LineC     = 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001;
  localparam logic [LW-1:0] LineFresh = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [LW-1:0] LineA     = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [LW-1:0] LineB     = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;

  cache_line_fill dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .req_line_i   (req_line),
    .req_word_i   (req_word),
    .busy_o       (busy),
    .mem_data_i   (mem_data),
    .mem_valid_i  (mem_valid),
    .mem_ready_o  (mem_ready),
    .crit_data_o  (crit_data),
    .crit_valid_o (crit_valid),
    .sram_en_o    (sram_en),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_data_o  (sram_data),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT produces an event; the SRAM
  // model latches the line at the end of the write cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (crit_valid) begin
        last_crit_cyc = cyc;
        checks++;
        if (crit_sb.size() == 0) begin
          failures++;
          $display("FAIL crit_unexpected: crit_data=%h at cycle %0d, required no pulse",
                   crit_data, cyc);
        end else begin
          ce = crit_sb.pop_front();
          if (crit_data !== ce.data || cyc != ce.cycle) begin
            failures++;
            $display("FAIL crit_word: got %h at cycle %0d, required %h at cycle %0d",
                     crit_data, cyc, ce.data, ce.cycle);
          end
        end
      end
      if (sram_we || sram_en) begin
        last_wr_cyc = cyc;
        wr_cnt++;
        checks++;
        if (wr_sb.size() == 0) begin
          failures++;
          $display("FAIL sram_write_unexpected: addr=%0d data=%h at cycle %0d, required none",
                   sram_addr, sram_data, cyc);
        end else begin
          we_e = wr_sb.pop_front();
          if (sram_we !== 1'b1 || sram_en !== 1'b1 || sram_addr !== we_e.addr ||
              sram_data !== we_e.data || cyc != we_e.cycle) begin
            failures++;
            $display("FAIL sram_write: en=%b we=%b addr=%0d data=%h cyc=%0d, required 1 1 %0d %h %0d",
                     sram_en, sram_we, sram_addr, sram_data, cyc, we_e.addr, we_e.data,
                     we_e.cycle);
          end
        end
        if (sram_we) sram_model[sram_addr] = sram_data;
      end
      if (done) begin
        last_done_cyc = cyc;
        done_cnt++;
        checks++;
        if (done_sb.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected: done at cycle %0d, required none", cyc);
        end else begin
          de = done_sb.pop_front();
          if (cyc != de) begin
            failures++;
            $display("FAIL done_cycle: got cycle %0d, required %0d", cyc, de);
          end
        end
      end
    end
  end

  // Drives one fill; gap bubbles precede every beat after the first. When drop
  // is set a second request (line 9) is pulsed during beat 1.
  task automatic do_fill(input logic [LIW-1:0] line, input logic [WIW-1:0] word,
                         input logic [LW-1:0] ln, input int gap, input bit drop,
                         output int req_edge);
    crit_exp_t ct;
    wr_exp_t   wt;
    int        n;
    req      = 1'b1;
    req_line = line;
    req_word = word;
    @(posedge clk); #1;
    req      = 1'b0;
    req_line = 6'd33;
    req_word = 2'd1;
    req_edge = cyc;
    checks++;
    if (busy !== 1'b1 || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_start: busy=%b mem_ready=%b, required 1 1", busy, mem_ready);
    end
    for (int k = 0; k < int'(WPL); k++) begin
      if (k > 0) begin
        repeat (gap) begin
          mem_valid = 1'b0;
          mem_data  = 32'hDEADBEEF;
          @(posedge clk); #1;
        end
      end
      mem_valid = 1'b1;
      mem_data  = ln[k*WW +: WW];
      if (drop && k == 1) begin
        req      = 1'b1;
        req_line = 6'd9;
      end
      if (k == int'(word)) begin
        ct.data  = ln[k*WW +: WW];
        ct.cycle = cyc + 1;
        crit_sb.push_back(ct);
      end
      if (k == int'(WPL) - 1) begin
        wt.addr  = line;
        wt.data  = ln;
        wt.cycle = cyc + 1;
        wr_sb.push_back(wt);
        done_sb.push_back(cyc + 2);
      end
      @(posedge clk); #1;
      req = 1'b0;
    end
    mem_valid = 1'b0;
    mem_data  = 32'hDEADBEEF;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    checks++;
    if (cyc - req_edge != int'(WPL) + 2 + gap * (int'(WPL) - 1)) begin
      failures++;
      $display("FAIL idle_latency: got %0d cycles, required %0d", cyc - req_edge,
               int'(WPL) + 2 + gap * (int'(WPL) - 1));
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (busy !== 1'b0 || mem_ready !== 1'b0 || crit_valid !== 1'b0 || sram_en !== 1'b0 ||
        sram_we !== 1'b0 || done !== 1'b0 || crit_data !== '0 || sram_addr !== '0 ||
        sram_data !== '0) begin
      failures++;
      $display("FAIL %s: busy=%b rdy=%b cv=%b en=%b we=%b done=%b cd=%h addr=%0d data=%h, required all 0",
               name, busy, mem_ready, crit_valid, sram_en, sram_we, done, crit_data,
               sram_addr, sram_data);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset_held");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_released");
  endtask

  task automatic test_basic();
    int e;
    do_fill(6'd5, 2'd2, LineBasic, 0, 1'b0, e);
    checks++;
    if (last_crit_cyc - e != 3 || last_wr_cyc - e != int'(WPL) ||
        last_done_cyc - e != int'(WPL) + 1) begin
      failures++;
      $display("FAIL basic_timing: crit=%0d wr=%0d done=%0d, required 3 %0d %0d",
               last_crit_cyc - e, last_wr_cyc - e, last_done_cyc - e, WPL, WPL + 1);
    end
    checks++;
    if (sram_model[5] !== LineBasic) begin
      failures++;
      $display("FAIL basic_line: got %h, required %h", sram_model[5], LineBasic);
    end
  endtask

  task automatic test_bubbles();
    int e;
    sram_model[5] = '0;
    do_fill(6'd5, 2'd2, LineBasic, 2, 1'b0, e);
    checks++;
    if (last_wr_cyc - e != int'(WPL) + 6) begin
      failures++;
      $display("FAIL bubble_write_delay: got %0d, required %0d", last_wr_cyc - e, WPL + 6);
    end
    checks++;
    if (sram_model[5] !== LineBasic) begin
      failures++;
      $display("FAIL bubble_line: got %h, required %h", sram_model[5], LineBasic);
    end
  endtask

  task automatic test_dropped();
    int e;
    int wr_before;
    wr_before = wr_cnt;
    do_fill(6'd7, 2'd1, LineC, 0, 1'b1, e);
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL dropped_refill: busy=%b, required 0", busy);
      end
    end
    checks++;
    if (wr_cnt - wr_before != 1 || sram_model[9] !== '0 || sram_model[7] !== LineC) begin
      failures++;
      $display("FAIL dropped_writes: writes=%0d line9=%h line7=%h, required 1 0 %h",
               wr_cnt - wr_before, sram_model[9], sram_model[7], LineC);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    int wr_before;
    int done_before;
    wr_before   = wr_cnt;
    done_before = done_cnt;
    req      = 1'b1;
    req_line = 6'd20;
    req_word = 2'd3;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_valid = 1'b1;
      mem_data  = 32'hBAD00000 + k;
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_async");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || wr_cnt != wr_before || done_cnt != done_before ||
        sram_model[20] !== '0) begin
      failures++;
      $display("FAIL reset_mid_effects: busy=%b writes=%0d dones=%0d line20=%h, required 0 0 0 0",
               busy, wr_cnt - wr_before, done_cnt - done_before, sram_model[20]);
    end
    do_fill(6'd21, 2'd0, LineFresh, 0, 1'b0, e);
    checks++;
    if (sram_model[21] !== LineFresh) begin
      failures++;
      $display("FAIL reset_mid_fresh: got %h, required %h", sram_model[21], LineFresh);
    end
  endtask

  task automatic test_back_to_back();
    int e1;
    int e2;
    int crit1;
    do_fill(6'd0, 2'd0, LineA, 0, 1'b0, e1);
    crit1 = last_crit_cyc;
    do_fill(6'd63, 2'd3, LineB, 0, 1'b0, e2);
    checks++;
    if (e2 - e1 != int'(WPL) + 3) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d, required %0d", e2 - e1, WPL + 3);
    end
    checks++;
    if (crit1 - e1 != 1 || last_crit_cyc != last_wr_cyc) begin
      failures++;
      $display("FAIL b2b_crit_timing: fill1 offset %0d, fill2 crit %0d write %0d, required 1 and equal",
               crit1 - e1, last_crit_cyc, last_wr_cyc);
    end
    checks++;
    if (sram_model[0] !== LineA || sram_model[63] !== LineB) begin
      failures++;
      $display("FAIL b2b_readback: line0=%h line63=%h, required %h %h",
               sram_model[0], sram_model[63], LineA, LineB);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NL); i++) sram_model[i] = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_dropped();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (crit_sb.size() != 0 || wr_sb.size() != 0 || done_sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: crit=%0d wr=%0d done=%0d left, required 0 0 0",
               crit_sb.size(), wr_sb.size(), done_sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
